// File: rtl/p3_sched.sv
// Scheduler for the three ping/pang/pong packet buffers: rotates each buffer through
// snooper -> CPU -> forwarder -> free, preserving packet arrival order.
module p3_sched #(
    parameter bit          ENABLE_FWD = 1'b1,
    parameter int unsigned SEL_WIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sn_req,
    input  logic                 sn_done,
    output logic                 sn_gnt,
    output logic [SEL_WIDTH-1:0] sn_sel,
    input  logic                 cpu_req,
    input  logic                 cpu_acc,
    input  logic                 cpu_rej,
    output logic                 cpu_gnt,
    output logic [SEL_WIDTH-1:0] cpu_sel,
    input  logic                 fwd_req,
    input  logic                 fwd_done,
    output logic                 fwd_gnt,
    output logic [SEL_WIDTH-1:0] fwd_sel,
    output logic [2:0]           buf_clr
);

    localparam int unsigned NBUF  = 3;
    localparam int unsigned CNT_W = 2;

    typedef enum logic [2:0] {
        B_FREE = 3'd0,
        B_SN   = 3'd1,
        B_RDY  = 3'd2,
        B_CPU  = 3'd3,
        B_ACC  = 3'd4,
        B_FWD  = 3'd5
    } buf_st_e;

    typedef logic [SEL_WIDTH-1:0] sel_t;

    buf_st_e          st_q   [NBUF];
    buf_st_e          st_d   [NBUF];
    sel_t             ord_q  [NBUF];
    sel_t             ord_d  [NBUF];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             sn_gnt_q,  sn_gnt_d;
    logic             cpu_gnt_q, cpu_gnt_d;
    logic             fwd_gnt_q, fwd_gnt_d;
    sel_t             sn_sel_q,  sn_sel_d;
    sel_t             cpu_sel_q, cpu_sel_d;
    sel_t             fwd_sel_q, fwd_sel_d;
    logic [NBUF-1:0]  buf_clr_q, buf_clr_d;
    logic [NBUF-1:0]  fresh_q,   fresh_d;

    logic             sn_fin, cpu_fin, fwd_fin;
    logic             sn_found, cpu_found, fwd_found;
    sel_t             sn_pick, cpu_pick, fwd_pick;
    logic [NBUF-1:0]  rm;
    logic [CNT_W-1:0] wr;

    // Grants, releases and arrival-order queue maintenance
    always_comb begin
        st_d      = st_q;
        ord_d     = ord_q;
        cnt_d     = cnt_q;
        sn_gnt_d  = sn_gnt_q;
        cpu_gnt_d = cpu_gnt_q;
        fwd_gnt_d = fwd_gnt_q;
        sn_sel_d  = sn_sel_q;
        cpu_sel_d = cpu_sel_q;
        fwd_sel_d = fwd_sel_q;
        fresh_d   = '0;
        buf_clr_d = '0;
        rm        = '0;
        wr        = '0;
        sn_found  = 1'b0;
        cpu_found = 1'b0;
        fwd_found = 1'b0;
        sn_pick   = '0;
        cpu_pick  = '0;
        fwd_pick  = '0;

        sn_fin  = sn_gnt_q & sn_done;
        cpu_fin = cpu_gnt_q & (cpu_acc | cpu_rej);
        fwd_fin = fwd_gnt_q & fwd_done;

        // Scan high-to-low so the lowest index / oldest queue entry wins
        for (int i = int'(NBUF) - 1; i >= 0; i--) begin
            if (st_q[i] == B_FREE && !fresh_q[i]) begin
                sn_found = 1'b1;
                sn_pick  = SEL_WIDTH'(i);
            end
            if (CNT_W'(i) < cnt_q && st_q[ord_q[i]] == B_RDY) begin
                cpu_found = 1'b1;
                cpu_pick  = ord_q[i];
            end
            if (CNT_W'(i) < cnt_q && st_q[ord_q[i]] == B_ACC) begin
                fwd_found = 1'b1;
                fwd_pick  = ord_q[i];
            end
        end

        if (sn_req && !sn_gnt_q && sn_found) begin
            st_d[sn_pick] = B_SN;
            sn_gnt_d      = 1'b1;
            sn_sel_d      = sn_pick;
        end
        if (cpu_req && !cpu_gnt_q && cpu_found) begin
            st_d[cpu_pick] = B_CPU;
            cpu_gnt_d      = 1'b1;
            cpu_sel_d      = cpu_pick;
        end
        if (fwd_req && !fwd_gnt_q && fwd_found) begin
            st_d[fwd_pick] = B_FWD;
            fwd_gnt_d      = 1'b1;
            fwd_sel_d      = fwd_pick;
        end

        if (sn_fin) begin
            st_d[sn_sel_q] = B_RDY;
            sn_gnt_d       = 1'b0;
        end
        if (cpu_fin) begin
            if (cpu_acc && ENABLE_FWD) begin
                st_d[cpu_sel_q] = B_ACC;
            end else begin
                st_d[cpu_sel_q] = B_FREE;
                rm[cpu_sel_q]   = 1'b1;
            end
            cpu_gnt_d = 1'b0;
        end
        if (fwd_fin) begin
            st_d[fwd_sel_q] = B_FREE;
            rm[fwd_sel_q]   = 1'b1;
            fwd_gnt_d       = 1'b0;
        end

        // Compact out freed buffers, then append the newly written packet
        for (int k = 0; k < int'(NBUF); k++) begin
            if (CNT_W'(k) < cnt_q && !rm[ord_q[k]]) begin
                ord_d[wr] = ord_q[k];
                wr        = CNT_W'(wr + 1'b1);
            end
        end
        if (sn_fin) begin
            ord_d[wr] = sn_sel_q;
            wr        = CNT_W'(wr + 1'b1);
        end
        cnt_d = wr;

        for (int i = 0; i < int'(NBUF); i++) begin
            fresh_d[i] = (st_d[i] == B_FREE) && (st_q[i] != B_FREE);
        end
        buf_clr_d = fresh_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q      <= '{default: B_FREE};
            ord_q     <= '{default: '0};
            cnt_q     <= '0;
            sn_gnt_q  <= 1'b0;
            cpu_gnt_q <= 1'b0;
            fwd_gnt_q <= 1'b0;
            sn_sel_q  <= '0;
            cpu_sel_q <= '0;
            fwd_sel_q <= '0;
            buf_clr_q <= '1;
            fresh_q   <= '0;
        end else begin
            st_q      <= st_d;
            ord_q     <= ord_d;
            cnt_q     <= cnt_d;
            sn_gnt_q  <= sn_gnt_d;
            cpu_gnt_q <= cpu_gnt_d;
            fwd_gnt_q <= fwd_gnt_d;
            sn_sel_q  <= sn_sel_d;
            cpu_sel_q <= cpu_sel_d;
            fwd_sel_q <= fwd_sel_d;
            buf_clr_q <= buf_clr_d;
            fresh_q   <= fresh_d;
        end
    end

    assign sn_gnt  = sn_gnt_q;
    assign sn_sel  = sn_sel_q;
    assign cpu_gnt = cpu_gnt_q;
    assign cpu_sel = cpu_sel_q;
    assign fwd_gnt = fwd_gnt_q;
    assign fwd_sel = fwd_sel_q;
    assign buf_clr = buf_clr_q;

endmodule

// File: tb/tb_p3_sched.sv
// Bench for p3_sched: directed scenarios plus random traffic against a queue-based model.
module tb_p3_sched;

    localparam bit FWD    = 1'b1;
    localparam int M_FREE = 0;
    localparam int M_SN   = 1;
    localparam int M_RDY  = 2;
    localparam int M_CPU  = 3;
    localparam int M_ACC  = 4;
    localparam int M_FWD  = 5;

    logic       clk;
    logic       rst_n;
    logic       sn_req, sn_done, cpu_req, cpu_acc, cpu_rej, fwd_req, fwd_done;
    logic       sn_gnt, cpu_gnt, fwd_gnt;
    logic [1:0] sn_sel, cpu_sel, fwd_sel;
    logic [2:0] buf_clr;

    int checks = 0;
    int errors = 0;

    // Reference model: buffer lifecycle states plus arrival-ordered packet list
    int       m_st [3];
    int       m_arr[$];
    bit       m_sn_gnt, m_cpu_gnt, m_fwd_gnt;
    int       m_sn_sel, m_cpu_sel, m_fwd_sel;
    bit [2:0] m_clr, m_fresh;

    p3_sched #(.ENABLE_FWD(FWD), .SEL_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .sn_req(sn_req), .sn_done(sn_done), .sn_gnt(sn_gnt), .sn_sel(sn_sel),
        .cpu_req(cpu_req), .cpu_acc(cpu_acc), .cpu_rej(cpu_rej), .cpu_gnt(cpu_gnt), .cpu_sel(cpu_sel),
        .fwd_req(fwd_req), .fwd_done(fwd_done), .fwd_gnt(fwd_gnt), .fwd_sel(fwd_sel),
        .buf_clr(buf_clr)
    );

    always #5 clk = ~clk;

    task automatic drop_pkt(input int b);
        for (int k = 0; k < m_arr.size(); k++) begin
            if (m_arr[k] == b) begin
                m_arr.delete(k);
                break;
            end
        end
    endtask

    function automatic int oldest_in(input int want);
        int r;
        r = -1;
        foreach (m_arr[k]) if (r < 0 && m_st[m_arr[k]] == want) r = m_arr[k];
        return r;
    endfunction

    task automatic model_step(input bit rn, sr, sd, cr, ca, cj, fr, fd);
        bit       osg, ocg, ofg;
        int       pick;
        bit [2:0] nclr;
        if (!rn) begin
            foreach (m_st[i]) m_st[i] = M_FREE;
            m_arr.delete();
            m_sn_gnt = 0; m_cpu_gnt = 0; m_fwd_gnt = 0;
            m_sn_sel = 0; m_cpu_sel = 0; m_fwd_sel = 0;
            m_clr = 3'b111; m_fresh = 3'b000;
        end else begin
            osg = m_sn_gnt; ocg = m_cpu_gnt; ofg = m_fwd_gnt;
            nclr = 3'b000;
            if (sr && !osg) begin
                pick = -1;
                for (int i = 2; i >= 0; i--) if (m_st[i] == M_FREE && !m_fresh[i]) pick = i;
                if (pick >= 0) begin m_st[pick] = M_SN; m_sn_gnt = 1; m_sn_sel = pick; end
            end
            if (cr && !ocg) begin
                pick = oldest_in(M_RDY);
                if (pick >= 0) begin m_st[pick] = M_CPU; m_cpu_gnt = 1; m_cpu_sel = pick; end
            end
            if (fr && !ofg) begin
                pick = oldest_in(M_ACC);
                if (pick >= 0) begin m_st[pick] = M_FWD; m_fwd_gnt = 1; m_fwd_sel = pick; end
            end
            if (osg && sd) begin
                m_st[m_sn_sel] = M_RDY;
                m_arr.push_back(m_sn_sel);
                m_sn_gnt = 0;
            end
            if (ocg && (ca || cj)) begin
                if (ca && FWD) m_st[m_cpu_sel] = M_ACC;
                else begin
                    m_st[m_cpu_sel] = M_FREE;
                    drop_pkt(m_cpu_sel);
                    nclr[m_cpu_sel] = 1'b1;
                end
                m_cpu_gnt = 0;
            end
            if (ofg && fd) begin
                m_st[m_fwd_sel] = M_FREE;
                drop_pkt(m_fwd_sel);
                nclr[m_fwd_sel] = 1'b1;
                m_fwd_gnt = 0;
            end
            m_clr = nclr; m_fresh = nclr;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rn, sr, sd, cr, ca, cj, fr, fd);
        rst_n = rn; sn_req = sr; sn_done = sd; cpu_req = cr;
        cpu_acc = ca; cpu_rej = cj; fwd_req = fr; fwd_done = fd;
        model_step(rn, sr, sd, cr, ca, cj, fr, fd);
        @(posedge clk);
        #1;
        chk("sn_gnt",  32'(sn_gnt),  32'(m_sn_gnt));
        chk("sn_sel",  32'(sn_sel),  32'(m_sn_sel));
        chk("cpu_gnt", 32'(cpu_gnt), 32'(m_cpu_gnt));
        chk("cpu_sel", 32'(cpu_sel), 32'(m_cpu_sel));
        chk("fwd_gnt", 32'(fwd_gnt), 32'(m_fwd_gnt));
        chk("fwd_sel", 32'(fwd_sel), 32'(m_fwd_sel));
        chk("buf_clr", 32'(buf_clr), 32'(m_clr));
        if (sn_gnt && cpu_gnt) chk("distinct_sn_cpu", 32'(sn_sel != cpu_sel), 32'd1);
        if (sn_gnt && fwd_gnt) chk("distinct_sn_fwd", 32'(sn_sel != fwd_sel), 32'd1);
        if (cpu_gnt && fwd_gnt) chk("distinct_cpu_fwd", 32'(cpu_sel != fwd_sel), 32'd1);
    endtask

    initial begin
        clk = 1'b0;
        // Reset
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_clr", 32'(buf_clr), 32'h7);
        chk("reset_gnts", 32'({sn_gnt, cpu_gnt, fwd_gnt}), 32'h0);

        // First grant right after reset release
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("first_sn_gnt", 32'(sn_gnt), 32'h1);
        chk("first_sn_sel", 32'(sn_sel), 32'h0);
        chk("first_clr", 32'(buf_clr), 32'h0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 1; k < 3; k++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0);
            chk("fill_sel", 32'(sn_sel), 32'(k));
            step(1, 0, 1, 0, 0, 0, 0, 0);
        end
        // All full: no grant
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("full_no_gnt", 32'(sn_gnt), 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // CPU rejects all three in arrival order
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 1, 0, 0, 0, 0);
            chk("rej_cpu_sel", 32'(cpu_sel), 32'(k));
            step(1, 0, 0, 0, 0, 1, 0, 0);
            chk("rej_clr", 32'(buf_clr), 32'(1 << k));
        end

        // Refill 0,1,2; accept+reject on buf0; reject buf1; refill buf1 behind buf2
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0, 0, 0, 0, 0);
            step(1, 0, 1, 0, 0, 0, 0, 0);
        end
        step(1, 0, 0, 1, 0, 0, 0, 0);
        chk("ar_cpu_sel", 32'(cpu_sel), 32'h0);
        step(1, 0, 0, 0, 1, 1, 0, 0);
        chk("acc_wins_clr", 32'(buf_clr), 32'h0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 0, 0);
        chk("rej1_clr", 32'(buf_clr), 32'h2);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("clr_cycle_not_eligible", 32'(sn_gnt), 32'h0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("refill_sel", 32'(sn_sel), 32'h1);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        chk("order_cpu_2", 32'(cpu_sel), 32'h2);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        chk("order_cpu_1", 32'(cpu_sel), 32'h1);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        chk("fwd_sel_0", 32'(fwd_sel), 32'h0);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        chk("fwd_clr_0", 32'(buf_clr), 32'h1);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        chk("fwd_sel_2", 32'(fwd_sel), 32'h2);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1, 0);
        chk("fwd_sel_1", 32'(fwd_sel), 32'h1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // All three agents granted, then reset mid-operation
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0, 1, 0);
        chk("all_gnt", 32'({sn_gnt, cpu_gnt, fwd_gnt}), 32'h7);
        step(0, 0, 1, 0, 1, 0, 0, 1);
        chk("rst_gnts", 32'({sn_gnt, cpu_gnt, fwd_gnt}), 32'h0);
        chk("rst_clr", 32'(buf_clr), 32'h7);
        step(1, 0, 1, 0, 1, 0, 0, 1);
        chk("post_rst_gnts", 32'({sn_gnt, cpu_gnt, fwd_gnt}), 32'h0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_sel", 32'(sn_sel), 32'h0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 249) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
